// File: rtl/srff_pkg.sv
// Shared types and limits for the SR flag bank: conflict-resolution modes,
// parameter range limits and the read-select width helper.
package srff_pkg;

    typedef enum logic [1:0] {
        SRF_SET_DOM = 2'd0,
        SRF_RST_DOM = 2'd1,
        SRF_TOGGLE  = 2'd2
    } srf_mode_e;

    localparam int CH_MIN    = 1;
    localparam int CH_MAX    = 32;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 16;

    function automatic int sel_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/srff_cell.sv
// One SR flag channel: optional rising-edge qualification of s, the flag itself,
// a saturating set-event counter and its sticky overflow bit.
module srff_cell
    import srff_pkg::*;
#(
    parameter srf_mode_e MODE  = SRF_SET_DOM,
    parameter int        EDGE  = 0,
    parameter int        CNT_W = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             en,
    input  logic             s,
    input  logic             r,
    input  logic             clr,
    output logic             q,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s_d_q;
    logic             q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             s_eff;
    logic             set_evt;

    always_comb begin
        s_eff = (EDGE != 0) ? (s & ~s_d_q) : s;
        q_d   = q_q;
        if (en) begin
            if (s_eff && !r)      q_d = 1'b1;
            else if (!s_eff && r) q_d = 1'b0;
            else if (s_eff && r) begin
                case (MODE)
                    SRF_SET_DOM: q_d = 1'b1;
                    SRF_RST_DOM: q_d = 1'b0;
                    default:     q_d = ~q_q;
                endcase
            end
        end
        set_evt = q_d & ~q_q;

        // Clear is applied first so an event on the same edge survives as cnt=1.
        cnt_d = clr ? '0 : cnt_q;
        ovf_d = clr ? 1'b0 : ovf_q;
        if (set_evt) begin
            if (cnt_d == CNT_MAX) ovf_d = 1'b1;
            else                  cnt_d = cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s_d_q <= 1'b0;
            q_q   <= 1'b0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            s_d_q <= s;
            q_q   <= q_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/srff_bank.sv
// Bank of CH independent SR flag channels with a registered counter read port
// (optional clear-on-read); out-of-range selects read as zero.
module srff_bank
    import srff_pkg::*;
#(
    parameter int        CH    = 8,
    parameter srf_mode_e MODE  = SRF_SET_DOM,
    parameter int        EDGE  = 0,
    parameter int        CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic [CH-1:0]            en,
    input  logic [CH-1:0]            s,
    input  logic [CH-1:0]            r,
    output logic [CH-1:0]            q,
    output logic                     any_q,
    output logic [CH-1:0]            ovf,
    input  logic                     rd_req,
    input  logic [sel_width(CH)-1:0] rd_sel,
    input  logic                     rd_clr,
    output logic                     rd_ack,
    output logic [CNT_W-1:0]         rd_cnt
);

    logic [CH-1:0][CNT_W-1:0] cnt;
    logic [CH-1:0]            clr_vec;
    logic                     sel_ok;
    logic                     rd_ack_q, rd_ack_d;
    logic [CNT_W-1:0]         rd_cnt_q, rd_cnt_d;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        srff_cell #(
            .MODE  (MODE),
            .EDGE  (EDGE),
            .CNT_W (CNT_W)
        ) u_cell (
            .clk  (clk),
            .clrn (clrn),
            .en   (en[i]),
            .s    (s[i]),
            .r    (r[i]),
            .clr  (clr_vec[i]),
            .q    (q[i]),
            .cnt  (cnt[i]),
            .ovf  (ovf[i])
        );
    end

    always_comb begin
        sel_ok   = int'(rd_sel) < CH;
        clr_vec  = '0;
        rd_ack_d = rd_req;
        rd_cnt_d = '0;
        if (rd_req && sel_ok) begin
            rd_cnt_d = cnt[rd_sel];
            if (rd_clr) clr_vec[rd_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rd_ack_q <= 1'b0;
            rd_cnt_q <= '0;
        end else begin
            rd_ack_q <= rd_ack_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign any_q  = |q;
    assign rd_ack = rd_ack_q;
    assign rd_cnt = rd_cnt_q;

endmodule

// File: doc/srff_bank.md
SRFF_BANK -- requirements
Module: srff_bank

Interface
REQ-001 Parameter CH, default 8: number of independent SR flag channels, 1..32.
REQ-002 Parameter MODE, default SRF_SET_DOM: resolution when s and r are both active (SRF_SET_DOM, SRF_RST_DOM, SRF_TOGGLE).
REQ-003 Parameter EDGE, default 0: 0 = level-sensitive s; 1 = s acts only on its rising edge.
REQ-004 Parameter CNT_W, default 4: width of each per-channel saturating set-event counter, 1..16.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 clrn  in  1  asynchronous, active-low reset.
REQ-007 en  in  CH  per-channel clock enable.
REQ-008 s  in  CH  per-channel set request.
REQ-009 r  in  CH  per-channel reset request.
REQ-010 q  out  CH  registered flag outputs.
REQ-011 any_q  out  1  OR of all q bits, combinational from q.
REQ-012 ovf  out  CH  sticky counter-overflow flags.
REQ-013 rd_req  in  1  counter read request, single-cycle strobe.
REQ-014 rd_sel  in  max(1,$clog2(CH))  channel index for the read.
REQ-015 rd_clr  in  1  clear selected counter and ovf on read.
REQ-016 rd_ack  out  1  one-cycle pulse, read data valid.
REQ-017 rd_cnt  out  CNT_W  counter value returned with rd_ack.

Function
REQ-018 Effective set s_eff[i] SHALL be s[i] when EDGE=0, and s[i] & ~s_d[i] when EDGE=1, s_d being s delayed one clk, updated every cycle independent of en.
REQ-019 With en[i]=0, q[i] SHALL hold.
REQ-020 With en[i]=1: s_eff&~r -> q=1; r&~s_eff -> q=0; neither -> hold.
REQ-021 With en[i]=1 and s_eff&r: SRF_SET_DOM -> 1; SRF_RST_DOM -> 0; SRF_TOGGLE -> ~q.
REQ-022 q SHALL change one clk edge after the qualifying inputs are sampled (latency 1).
REQ-023 A set event SHALL be a 0->1 transition of q[i]; each event increments cnt[i] by 1.
REQ-024 cnt[i] SHALL saturate at 2^CNT_W-1; an event at saturation SHALL set ovf[i], which stays 1 until cleared by reset or read-clear.
REQ-025 rd_req sampled high SHALL produce rd_ack=1 on the next cycle with rd_cnt = cnt[rd_sel] as it was before that edge.
REQ-026 rd_req with rd_clr=1 SHALL clear cnt[rd_sel] and ovf[rd_sel] on the same edge that captures rd_cnt.
REQ-027 Clear coinciding with a set event on the same channel SHALL leave cnt=1, ovf=0 (no event lost).
REQ-028 rd_req SHALL be accepted every cycle (back-to-back), independent of rd_ack.
REQ-029 rd_sel >= CH SHALL return rd_cnt=0 with rd_ack=1 and clear nothing.
REQ-030 rd_cnt SHALL be 0 whenever rd_ack=0.

Reset
REQ-031 clrn=0 SHALL immediately force q, s_d, every cnt, ovf, rd_ack and rd_cnt to 0, regardless of clk.
REQ-032 Reset asserted mid-read SHALL suppress the pending rd_ack.
REQ-033 After clrn rises, the first clk edge SHALL operate normally; with EDGE=1, s already high at release counts as a rising edge.

Structure
REQ-034 Shared package srff_pkg SHALL hold the mode enum (SRF_SET_DOM, SRF_RST_DOM, SRF_TOGGLE) and CH/CNT_W range limits.
REQ-035 One sub-module srff_cell SHALL implement a single channel (edge detect, flag, counter, ovf), instantiated CH times; read mux and rd_ack live in srff_bank.

Verification
REQ-036 CH=8, EDGE=0, SET_DOM: en=FF, s=01 one cycle -> q=01 next cycle, any_q=1; r=01 -> q=00, any_q=0.
REQ-037 s=r=1 on ch0 for three cycles: SET_DOM -> q0=1; RST_DOM -> q0=0; TOGGLE -> q0 sequence 1,0,1.
REQ-038 EDGE=1: s0 held high 5 cycles with r0 pulsed in cycle 3 -> q0 set once, cleared, not re-set; cnt0=1.
REQ-039 CNT_W=2: 5 set/reset pairs on ch2 -> cnt2=3, ovf[2]=1; rd_req, rd_sel=2, rd_clr=1 -> rd_ack next cycle with rd_cnt=3; following read gives 0, ovf[2]=0.
REQ-040 Read-clear of ch1 on the same edge as a ch1 set event -> rd_cnt=old value, subsequent read gives 1.
REQ-041 clrn pulsed low between clk edges while q=FF and a read pending -> q=00, counters 0, no rd_ack.
